l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter_if.sv | 47 ++++
 rtl/l2_arbiter.sv | 139 +++++++++++++
 tb/tb_l2_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_if.sv
// L1<->L2 arbiter bus: both cores' request ports, the L2 array port and snoop outputs.
// Parameter n is the data word width.
interface l2_arbiter_if #(parameter int n = 32);
  logic         c0_read_request, c0_write_request;
  logic [9:0]   c0_word_address;
  logic [n-1:0] c0_write_word;
  logic         c1_read_request, c1_write_request;
  logic [9:0]   c1_word_address;
  logic [n-1:0] c1_write_word;
  logic [n-1:0] l2_read_word;
  logic [9:0]   l2_word_address;
  logic [n-1:0] l2_write_word;
  logic         l2_write_en;
  logic         c0_l2_busy, c1_l2_busy;
  logic [n-1:0] c0_read_word, c1_read_word;
  logic         c0_others_read_request, c0_others_write_request;
  logic [3:0]   c0_others_block_tag, c0_others_block_index;
  logic         c1_others_read_request, c1_others_write_request;
  logic [3:0]   c1_others_block_tag, c1_others_block_index;
  logic [31:0]  arb_statistics;

  modport slave (
    input  c0_read_request, c0_write_request, c0_word_address, c0_write_word,
    input  c1_read_request, c1_write_request, c1_word_address, c1_write_word,
    input  l2_read_word,
    output l2_word_address, l2_write_word, l2_write_en,
    output c0_l2_busy, c1_l2_busy, c0_read_word, c1_read_word,
    output c0_others_read_request, c0_others_write_request,
    output c0_others_block_tag, c0_others_block_index,
    output c1_others_read_request, c1_others_write_request,
    output c1_others_block_tag, c1_others_block_index,
    output arb_statistics
  );

  modport master (
    output c0_read_request, c0_write_request, c0_word_address, c0_write_word,
    output c1_read_request, c1_write_request, c1_word_address, c1_write_word,
    output l2_read_word,
    input  l2_word_address, l2_write_word, l2_write_en,
    input  c0_l2_busy, c1_l2_busy, c0_read_word, c1_read_word,
    input  c0_others_read_request, c0_others_write_request,
    input  c0_others_block_tag, c0_others_block_index,
    input  c1_others_read_request, c1_others_write_request,
    input  c1_others_block_tag, c1_others_block_index,
    input  arb_statistics
  );
endinterface

// File: rtl/l2_arbiter.sv
// Two-core L2 port arbiter with round-robin contention, direct handoff and snoop broadcast.
// Define ARB_STATISTICS_EN to build grant/conflict/max-wait counters on arb_statistics.
module l2_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  l2_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e state_q, state_d;
  logic   last_owner_q, last_owner_d;
  logic   req0, req1;
  logic   busy0, busy1;
  logic [n-1:0] wword;

  assign req0 = bus.c0_read_request | bus.c0_write_request;
  assign req1 = bus.c1_read_request | bus.c1_write_request;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_owner_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: if (!req0) begin
        last_owner_d = 1'b0;
        state_d      = req1 ? OWN1 : IDLE;
      end
      OWN1: if (!req1) begin
        last_owner_d = 1'b1;
        state_d      = req0 ? OWN0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write wins over read for both the strobe and the snoop type.
  always_comb begin
    busy0 = req0 && (state_q != OWN0);
    busy1 = req1 && (state_q != OWN1);
    bus.c0_l2_busy   = busy0;
    bus.c1_l2_busy   = busy1;
    bus.c0_read_word = bus.l2_read_word;
    bus.c1_read_word = bus.l2_read_word;
    bus.l2_word_address         = '0;
    wword                       = '0;
    bus.l2_write_en             = 1'b0;
    bus.c0_others_read_request  = 1'b0;
    bus.c0_others_write_request = 1'b0;
    bus.c0_others_block_tag     = '0;
    bus.c0_others_block_index   = '0;
    bus.c1_others_read_request  = 1'b0;
    bus.c1_others_write_request = 1'b0;
    bus.c1_others_block_tag     = '0;
    bus.c1_others_block_index   = '0;
    unique case (state_q)
      OWN0: begin
        bus.l2_word_address         = bus.c0_word_address;
        wword                       = bus.c0_write_word;
        bus.l2_write_en             = bus.c0_write_request;
        bus.c1_others_read_request  = bus.c0_read_request & ~bus.c0_write_request;
        bus.c1_others_write_request = bus.c0_write_request;
        bus.c1_others_block_tag     = bus.c0_word_address[9:6];
        bus.c1_others_block_index   = bus.c0_word_address[5:2];
      end
      OWN1: begin
        bus.l2_word_address         = bus.c1_word_address;
        wword                       = bus.c1_write_word;
        bus.l2_write_en             = bus.c1_write_request;
        bus.c0_others_read_request  = bus.c1_read_request & ~bus.c1_write_request;
        bus.c0_others_write_request = bus.c1_write_request;
        bus.c0_others_block_tag     = bus.c1_word_address[9:6];
        bus.c0_others_block_index   = bus.c1_word_address[5:2];
      end
      default: ;
    endcase
    bus.l2_write_word = wword;
  end

`ifdef ARB_STATISTICS_EN
  logic [7:0] grants0_q, grants0_d, grants1_q, grants1_d;
  logic [7:0] conflicts_q, conflicts_d, max_wait_q, max_wait_d;
  logic [7:0] wait0_q, wait0_d, wait1_q, wait1_d;

  // wait counters hold the length of the current stall run, including this cycle
  always_comb begin
    grants0_d   = grants0_q;
    grants1_d   = grants1_q;
    conflicts_d = conflicts_q;
    if (state_d == OWN0 && state_q != OWN0 && grants0_q != 8'hff) grants0_d = grants0_q + 8'd1;
    if (state_d == OWN1 && state_q != OWN1 && grants1_q != 8'hff) grants1_d = grants1_q + 8'd1;
    if (req0 && req1 && conflicts_q != 8'hff) conflicts_d = conflicts_q + 8'd1;
    wait0_d = busy0 ? ((wait0_q == 8'hff) ? 8'hff : wait0_q + 8'd1) : 8'd0;
    wait1_d = busy1 ? ((wait1_q == 8'hff) ? 8'hff : wait1_q + 8'd1) : 8'd0;
    max_wait_d = max_wait_q;
    if (wait0_d > max_wait_d) max_wait_d = wait0_d;
    if (wait1_d > max_wait_d) max_wait_d = wait1_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grants0_q   <= '0;
      grants1_q   <= '0;
      conflicts_q <= '0;
      max_wait_q  <= '0;
      wait0_q     <= '0;
      wait1_q     <= '0;
    end else begin
      grants0_q   <= grants0_d;
      grants1_q   <= grants1_d;
      conflicts_q <= conflicts_d;
      max_wait_q  <= max_wait_d;
      wait0_q     <= wait0_d;
      wait1_q     <= wait1_d;
    end
  end

  assign bus.arb_statistics = {grants0_q, grants1_q, conflicts_q, max_wait_q};
`else
  assign bus.arb_statistics = 32'd0;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: grant latency, contention, handoff, snoop, reset abort, stats.
module tb_l2_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   fails = 0;

  l2_arbiter_if #(.n(32)) bus ();
  l2_arbiter #(.n(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_snoop_zero(input string tag);
    chk({tag, "_c0snp"}, {22'd0, bus.c0_others_read_request, bus.c0_others_write_request,
        bus.c0_others_block_tag, bus.c0_others_block_index}, 32'd0);
    chk({tag, "_c1snp"}, {22'd0, bus.c1_others_read_request, bus.c1_others_write_request,
        bus.c1_others_block_tag, bus.c1_others_block_index}, 32'd0);
  endtask

  initial begin
    bus.c0_read_request = 0; bus.c0_write_request = 0;
    bus.c0_word_address = '0; bus.c0_write_word = '0;
    bus.c1_read_request = 0; bus.c1_write_request = 0;
    bus.c1_word_address = '0; bus.c1_write_word = '0;
    bus.l2_read_word = 32'h1234_5678;

    // reset state
    do_reset();
    chk("rst_addr", {22'd0, bus.l2_word_address}, 32'd0);
    chk("rst_wen", {31'd0, bus.l2_write_en}, 32'd0);
    chk("rst_wword", bus.l2_write_word, 32'd0);
    chk_snoop_zero("rst");
    chk("rst_stats", bus.arb_statistics, 32'd0);
    chk("bcast_rd0", bus.c0_read_word, 32'h1234_5678);
    chk("bcast_rd1", bus.c1_read_word, 32'h1234_5678);

    // single c0 read at 0x155: one stall cycle then ownership
    bus.c0_read_request = 1; bus.c0_word_address = 10'h155;
    #1;
    chk("s1_busy_idle", {31'd0, bus.c0_l2_busy}, 32'd1);
    chk("s1_addr_idle", {22'd0, bus.l2_word_address}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_busy_own", {31'd0, bus.c0_l2_busy}, 32'd0);
      chk("s1_addr", {22'd0, bus.l2_word_address}, 32'h155);
      chk("s1_snp_rd", {31'd0, bus.c1_others_read_request}, 32'd1);
      chk("s1_snp_tag", {28'd0, bus.c1_others_block_tag}, 32'h5);
      chk("s1_snp_idx", {28'd0, bus.c1_others_block_index}, 32'h5);
    end
    bus.c0_read_request = 0;
    step();
    chk("s1_idle_addr", {22'd0, bus.l2_word_address}, 32'd0);
    chk_snoop_zero("s1_idle");

    // contention after reset: core 0 first, direct handoff to core 1
    do_reset();
    bus.c0_read_request = 1; bus.c0_word_address = 10'h011;
    bus.c1_read_request = 1; bus.c1_word_address = 10'h022;
    #1;
    chk("s2_busy0_idle", {31'd0, bus.c0_l2_busy}, 32'd1);
    chk("s2_busy1_idle", {31'd0, bus.c1_l2_busy}, 32'd1);
    step();
    chk("s2_own0_addr", {22'd0, bus.l2_word_address}, 32'h011);
    chk("s2_own0_busy0", {31'd0, bus.c0_l2_busy}, 32'd0);
    chk("s2_own0_busy1", {31'd0, bus.c1_l2_busy}, 32'd1);
    step();
    chk("s2_own0_busy1b", {31'd0, bus.c1_l2_busy}, 32'd1);
    bus.c0_read_request = 0;
    #1;
    chk("s2_drop_busy1", {31'd0, bus.c1_l2_busy}, 32'd1);
    chk("s2_drop_busy0", {31'd0, bus.c0_l2_busy}, 32'd0);
    step();
    chk("s2_handoff_addr", {22'd0, bus.l2_word_address}, 32'h022);
    chk("s2_handoff_busy1", {31'd0, bus.c1_l2_busy}, 32'd0);
    chk("s2_handoff_snp", {31'd0, bus.c0_others_read_request}, 32'd1);
    bus.c1_read_request = 0;
    step();
    chk("s2_idle_addr", {22'd0, bus.l2_word_address}, 32'd0);

    // a lone c0 grant leaves last_owner=0, so the next contention favours core 1
    bus.c0_read_request = 1;
    step();
    bus.c0_read_request = 0;
    step();
    bus.c0_read_request = 1; bus.c1_read_request = 1;
    #1;
    chk("s3_busy1_idle", {31'd0, bus.c1_l2_busy}, 32'd1);
    step();
    chk("s3_addr", {22'd0, bus.l2_word_address}, 32'h022);
    chk("s3_busy1", {31'd0, bus.c1_l2_busy}, 32'd0);
    chk("s3_busy0", {31'd0, bus.c0_l2_busy}, 32'd1);
    bus.c0_read_request = 0; bus.c1_read_request = 0;
    step();

    // c1 write 0x2A3 / 0xDEADBEEF; c0 idle never stalls
    bus.c1_write_request = 1; bus.c1_word_address = 10'h2A3; bus.c1_write_word = 32'hDEADBEEF;
    #1;
    chk("s4_busy0_idle", {31'd0, bus.c0_l2_busy}, 32'd0);
    chk("s4_wen_idle", {31'd0, bus.l2_write_en}, 32'd0);
    step();
    chk("s4_wen", {31'd0, bus.l2_write_en}, 32'd1);
    chk("s4_wword", bus.l2_write_word, 32'hDEADBEEF);
    chk("s4_addr", {22'd0, bus.l2_word_address}, 32'h2A3);
    chk("s4_snp_wr", {31'd0, bus.c0_others_write_request}, 32'd1);
    chk("s4_snp_tag", {28'd0, bus.c0_others_block_tag}, 32'hA);
    chk("s4_snp_idx", {28'd0, bus.c0_others_block_index}, 32'h8);
    chk("s4_busy0", {31'd0, bus.c0_l2_busy}, 32'd0);
    chk("s4_c1snp_zero", {31'd0, bus.c1_others_write_request}, 32'd0);
    // read and write together: write wins
    bus.c1_read_request = 1;
    step();
    chk("s4_rw_wen", {31'd0, bus.l2_write_en}, 32'd1);
    chk("s4_rw_snp_wr", {31'd0, bus.c0_others_write_request}, 32'd1);
    chk("s4_rw_snp_rd", {31'd0, bus.c0_others_read_request}, 32'd0);
    bus.c1_read_request = 0;

    // reset during OWN1 with the write still pending
    reset = 1'b1;
    step();
    chk("s5_wen", {31'd0, bus.l2_write_en}, 32'd0);
    chk("s5_addr", {22'd0, bus.l2_word_address}, 32'd0);
    chk("s5_wword", bus.l2_write_word, 32'd0);
    chk_snoop_zero("s5");
    chk("s5_busy1", {31'd0, bus.c1_l2_busy}, 32'd1);
    reset = 1'b0;
    bus.c1_write_request = 0;
    step();

    // 300 grants to each core, alternating
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.c0_read_request = 1; step();
      bus.c0_read_request = 0; step();
      bus.c1_read_request = 1; step();
      bus.c1_read_request = 0; step();
    end
`ifdef ARB_STATISTICS_EN
    chk("s6_stats", bus.arb_statistics, {8'd255, 8'd255, 8'd0, 8'd1});
`else
    chk("s6_stats", bus.arb_statistics, 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
